// File: rtl/mem_xbar_pkg.sv
// rtl/mem_xbar_pkg.sv - address map, state types and decode helpers for mem_xbar
package mem_xbar_pkg;

    localparam int MAX_SLAVES = 4;

    // Index order is decode priority: on overlapping windows the lowest index wins.
    localparam logic [63:0] SLAVE_BASE [MAX_SLAVES] = '{
        64'h0000_0000_8000_0000,    // axi
        64'h0000_0000_0200_0000,    // clint
        64'h0000_0000_0100_0000,    // uart
        64'h0000_0000_0000_0000     // bram
    };

    localparam logic [63:0] SLAVE_TOP [MAX_SLAVES] = '{
        64'h0000_0000_9000_0000,
        64'h0000_0000_0200_C000,
        64'h0000_0000_0100_0004,
        64'h0000_0000_0010_0000
    };

    typedef enum logic [1:0] {
        M_IDLE,
        M_WAIT,
        M_ISSUED,
        M_ERR
    } mstate_t;

    typedef enum logic {
        S_FREE,
        S_BUSY
    } sstate_t;

    function automatic logic slave_hit(input int k, input logic [63:0] addr);
        logic hit;
        hit = 1'b0;
        if (k >= 0 && k < MAX_SLAVES)
            hit = (addr >= SLAVE_BASE[k[1:0]]) && (addr < SLAVE_TOP[k[1:0]]);
        return hit;
    endfunction

    function automatic logic [63:0] slave_base(input int k);
        logic [63:0] base;
        base = 64'd0;
        if (k >= 0 && k < MAX_SLAVES)
            base = SLAVE_BASE[k[1:0]];
        return base;
    endfunction

endpackage

// File: rtl/mem_xbar_rr_arbiter.sv
// rtl/mem_xbar_rr_arbiter.sv - round-robin arbiter with one-hot grant
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic [PW-1:0] idx;
    logic          found;

    // Search starts at ptr so the most recent winner has lowest priority next time.
    always_comb begin
        grant = '0;
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                win        = idx;
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            ptr <= '0;
        else if (advance && found)
            ptr <= (win == PW'(N - 1)) ? '0 : win + PW'(1);
    end

endmodule

// File: rtl/mem_xbar.sv
// rtl/mem_xbar.sv - multi-master to multi-slave memory crossbar with per-slave round-robin
module mem_xbar
    import mem_xbar_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic [NUM_MASTERS-1:0]                  m_valid,
    input  logic [NUM_MASTERS-1:0]                  m_instr,
    input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]  m_addr,
    input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]  m_wdata,
    input  logic [NUM_MASTERS-1:0][DATA_WIDTH/8-1:0] m_wstrb,
    output logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]  m_rdata,
    output logic [NUM_MASTERS-1:0]                  m_ready,
    output logic [NUM_MASTERS-1:0]                  m_error,
    output logic [NUM_SLAVES-1:0]                   s_valid,
    output logic [NUM_SLAVES-1:0]                   s_instr,
    output logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0]   s_addr,
    output logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0]   s_wdata,
    output logic [NUM_SLAVES-1:0][DATA_WIDTH/8-1:0] s_wstrb,
    input  logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0]   s_rdata,
    input  logic [NUM_SLAVES-1:0]                   s_ready
);

    localparam int SW  = DATA_WIDTH / 8;
    localparam int MIW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int SIW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    logic rst_q;
    logic live;

    mstate_t         m_state [NUM_MASTERS];
    logic [ADDR_WIDTH-1:0] h_addr  [NUM_MASTERS];
    logic [DATA_WIDTH-1:0] h_wdata [NUM_MASTERS];
    logic [SW-1:0]         h_wstrb [NUM_MASTERS];
    logic                  h_instr [NUM_MASTERS];
    logic [SIW-1:0]        h_tgt   [NUM_MASTERS];

    sstate_t         s_state [NUM_SLAVES];
    logic [MIW-1:0]  s_owner [NUM_SLAVES];

    logic [NUM_MASTERS-1:0] d_hit;
    logic [SIW-1:0]         d_idx [NUM_MASTERS];
    logic [ADDR_WIDTH-1:0]  d_off [NUM_MASTERS];

    logic [NUM_MASTERS-1:0] c_want;
    logic [SIW-1:0]         c_tgt   [NUM_MASTERS];
    logic [ADDR_WIDTH-1:0]  c_addr  [NUM_MASTERS];
    logic [DATA_WIDTH-1:0]  c_wdata [NUM_MASTERS];
    logic [SW-1:0]          c_wstrb [NUM_MASTERS];
    logic                   c_instr [NUM_MASTERS];

    logic [NUM_MASTERS-1:0] arb_req [NUM_SLAVES];
    logic [NUM_MASTERS-1:0] arb_gnt [NUM_SLAVES];
    logic [NUM_SLAVES-1:0]  arb_adv;
    logic [MIW-1:0]         gnt_idx [NUM_SLAVES];
    logic [NUM_MASTERS-1:0] m_granted;
    logic [NUM_MASTERS-1:0] m_done;
    logic [NUM_SLAVES-1:0]  s_rel;

    // Outputs and requests stay quiet for the reset cycle and the one after it.
    assign live = !reset && !rst_q;

    always_comb begin
        for (int m = 0; m < NUM_MASTERS; m++) begin
            d_hit[m] = 1'b0;
            d_idx[m] = '0;
            d_off[m] = '0;
            for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
                if (slave_hit(k, 64'(m_addr[m]))) begin
                    d_hit[m] = 1'b1;
                    d_idx[m] = SIW'(k);
                    d_off[m] = ADDR_WIDTH'(64'(m_addr[m]) - slave_base(k));
                end
            end
        end
    end

    // An idle master requests straight from its inputs; a waiting one from its holding register.
    always_comb begin
        for (int m = 0; m < NUM_MASTERS; m++) begin
            c_want[m] = live && (((m_state[m] == M_IDLE) && m_valid[m] && d_hit[m])
                                 || (m_state[m] == M_WAIT));
            if (m_state[m] == M_IDLE) begin
                c_tgt[m]   = d_idx[m];
                c_addr[m]  = d_off[m];
                c_wdata[m] = m_wdata[m];
                c_wstrb[m] = m_wstrb[m];
                c_instr[m] = m_instr[m];
            end else begin
                c_tgt[m]   = h_tgt[m];
                c_addr[m]  = h_addr[m];
                c_wdata[m] = h_wdata[m];
                c_wstrb[m] = h_wstrb[m];
                c_instr[m] = h_instr[m];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_SLAVES; k++) begin
            arb_req[k] = '0;
            for (int m = 0; m < NUM_MASTERS; m++)
                arb_req[k][m] = c_want[m] && (c_tgt[m] == SIW'(k)) && (s_state[k] == S_FREE);
            arb_adv[k] = |arb_req[k];
        end
    end

    for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_arb
        rr_arbiter #(.N(NUM_MASTERS)) u_arb (
            .clock   (clock),
            .reset   (reset),
            .req     (arb_req[k]),
            .advance (arb_adv[k]),
            .grant   (arb_gnt[k])
        );
    end

    always_comb begin
        s_valid   = '0;
        s_instr   = '0;
        s_addr    = '0;
        s_wdata   = '0;
        s_wstrb   = '0;
        m_granted = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            gnt_idx[k] = '0;
            for (int m = 0; m < NUM_MASTERS; m++) begin
                if (arb_gnt[k][m]) begin
                    gnt_idx[k]   = MIW'(m);
                    m_granted[m] = 1'b1;
                    s_valid[k]   = 1'b1;
                    s_instr[k]   = c_instr[m];
                    s_addr[k]    = c_addr[m];
                    s_wdata[k]   = c_wdata[m];
                    s_wstrb[k]   = c_wstrb[m];
                end
            end
        end
    end

    // A response only counts when it comes from a busy slave owned by the waiting master.
    always_comb begin
        m_ready = '0;
        m_error = '0;
        m_rdata = '0;
        m_done  = '0;
        for (int k = 0; k < NUM_SLAVES; k++)
            s_rel[k] = live && (s_state[k] == S_BUSY) && s_ready[k];
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (live && m_state[m] == M_ERR) begin
                m_ready[m] = 1'b1;
                m_error[m] = 1'b1;
            end else if (m_state[m] == M_ISSUED) begin
                for (int k = 0; k < NUM_SLAVES; k++) begin
                    if (s_rel[k] && (h_tgt[m] == SIW'(k)) && (s_owner[k] == MIW'(m))) begin
                        m_done[m]  = 1'b1;
                        m_ready[m] = 1'b1;
                        m_rdata[m] = s_rdata[k];
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        rst_q <= reset;
        if (reset) begin
            for (int m = 0; m < NUM_MASTERS; m++) begin
                m_state[m] <= M_IDLE;
                h_addr[m]  <= '0;
                h_wdata[m] <= '0;
                h_wstrb[m] <= '0;
                h_instr[m] <= 1'b0;
                h_tgt[m]   <= '0;
            end
            for (int k = 0; k < NUM_SLAVES; k++) begin
                s_state[k] <= S_FREE;
                s_owner[k] <= '0;
            end
        end else begin
            for (int m = 0; m < NUM_MASTERS; m++) begin
                case (m_state[m])
                    M_IDLE: begin
                        if (live && m_valid[m]) begin
                            if (d_hit[m]) begin
                                h_addr[m]  <= d_off[m];
                                h_wdata[m] <= m_wdata[m];
                                h_wstrb[m] <= m_wstrb[m];
                                h_instr[m] <= m_instr[m];
                                h_tgt[m]   <= d_idx[m];
                                m_state[m] <= m_granted[m] ? M_ISSUED : M_WAIT;
                            end else begin
                                m_state[m] <= M_ERR;
                            end
                        end
                    end
                    M_WAIT:   if (m_granted[m]) m_state[m] <= M_ISSUED;
                    M_ISSUED: if (m_done[m]) m_state[m] <= M_IDLE;
                    default:  m_state[m] <= M_IDLE;
                endcase
            end
            for (int k = 0; k < NUM_SLAVES; k++) begin
                if (s_rel[k]) begin
                    s_state[k] <= S_FREE;
                end else if (|arb_gnt[k]) begin
                    s_state[k] <= S_BUSY;
                    s_owner[k] <= gnt_idx[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_xbar.sv
// tb/tb_mem_xbar.sv - directed self-checking bench for mem_xbar
module tb_mem_xbar;

    localparam int NM = 2;
    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic                       clock = 1'b0;
    logic                       reset;
    logic [NM-1:0]              m_valid;
    logic [NM-1:0]              m_instr;
    logic [NM-1:0][AW-1:0]      m_addr;
    logic [NM-1:0][DW-1:0]      m_wdata;
    logic [NM-1:0][SW-1:0]      m_wstrb;
    logic [NM-1:0][DW-1:0]      m_rdata;
    logic [NM-1:0]              m_ready;
    logic [NM-1:0]              m_error;
    logic [NS-1:0]              s_valid;
    logic [NS-1:0]              s_instr;
    logic [NS-1:0][AW-1:0]      s_addr;
    logic [NS-1:0][DW-1:0]      s_wdata;
    logic [NS-1:0][SW-1:0]      s_wstrb;
    logic [NS-1:0][DW-1:0]      s_rdata;
    logic [NS-1:0]              s_ready;

    int checks = 0;
    int errors = 0;

    mem_xbar #(
        .NUM_MASTERS (NM),
        .NUM_SLAVES  (NS),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .m_valid (m_valid),
        .m_instr (m_instr),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_wstrb (m_wstrb),
        .m_rdata (m_rdata),
        .m_ready (m_ready),
        .m_error (m_error),
        .s_valid (s_valid),
        .s_instr (s_instr),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_wstrb (s_wstrb),
        .s_rdata (s_rdata),
        .s_ready (s_ready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
        m_valid = '0;
        m_instr = '0;
        s_ready = '0;
    endtask

    task automatic req(input logic m, input logic [31:0] a, input logic [3:0] st, input logic [31:0] wd);
        m_valid[m] = 1'b1;
        m_addr[m]  = a;
        m_wstrb[m] = st;
        m_wdata[m] = wd;
    endtask

    task automatic rsp(input logic [1:0] k, input logic [31:0] d);
        s_ready[k] = 1'b1;
        s_rdata[k] = d;
    endtask

    initial begin
        reset   = 1'b1;
        m_valid = '0;
        m_instr = '0;
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
        s_ready = '0;
        s_rdata = '0;

        // Reset cycle and the cycle after: requests are ignored, outputs stay 0
        cyc();
        req(1'b1, 32'h0000_0010, 4'h0, 32'h0); #1;
        chk("rst_s_valid", s_valid, 4'b0000);
        chk("rst_m_ready", m_ready, 2'b00);
        cyc();
        reset = 1'b0;
        req(1'b1, 32'h0000_0010, 4'h0, 32'h0); #1;
        chk("post_rst_s_valid", s_valid, 4'b0000);
        chk("post_rst_m_ready", m_ready, 2'b00);
        cyc();

        // M1 read from bram, issued in the request cycle
        cyc();
        req(1'b1, 32'h0000_0010, 4'h0, 32'h0);
        m_instr[1] = 1'b1; #1;
        chk("rd_s_valid", s_valid, 4'b1000);
        chk("rd_s_addr", s_addr[3], 32'h10);
        chk("rd_s_instr", s_instr, 4'b1000);
        chk("rd_m_ready_early", m_ready, 2'b00);
        cyc();
        rsp(2'd3, 32'hDEAD_BEEF); #1;
        chk("rd_m_ready", m_ready, 2'b10);
        chk("rd_m_rdata", m_rdata[1], 32'hDEAD_BEEF);
        chk("rd_m_error", m_error, 2'b00);
        cyc(); #1;
        chk("rd_m_ready_pulse", m_ready, 2'b00);

        // Contention on bram: M0 wins first, M1 waits
        cyc();
        req(1'b0, 32'h0000_0040, 4'h0, 32'h0);
        req(1'b1, 32'h0000_0040, 4'hF, 32'h1111_1111); #1;
        chk("ct_s_valid", s_valid, 4'b1000);
        chk("ct_s_wstrb_m0", s_wstrb[3], 4'h0);
        chk("ct_s_addr", s_addr[3], 32'h40);
        cyc(); #1;
        chk("ct_busy_s_valid", s_valid, 4'b0000);
        cyc();
        rsp(2'd3, 32'h0000_00A0); #1;
        chk("ct_m0_ready", m_ready, 2'b01);
        chk("ct_m0_rdata", m_rdata[0], 32'hA0);
        chk("ct_no_reissue", s_valid, 4'b0000);
        // M0 re-requests while M1 still waits: pointer now favours M1
        cyc();
        req(1'b0, 32'h0000_0044, 4'h0, 32'h0); #1;
        chk("ct2_s_valid", s_valid, 4'b1000);
        chk("ct2_s_wstrb_m1", s_wstrb[3], 4'hF);
        chk("ct2_s_wdata_m1", s_wdata[3], 32'h1111_1111);
        chk("ct2_s_addr_m1", s_addr[3], 32'h40);
        cyc();
        rsp(2'd3, 32'h0); #1;
        chk("ct2_m1_ready", m_ready, 2'b10);
        cyc(); #1;
        chk("ct2_m0_issue", s_valid, 4'b1000);
        chk("ct2_m0_addr", s_addr[3], 32'h44);
        chk("ct2_m0_wstrb", s_wstrb[3], 4'h0);
        cyc();
        rsp(2'd3, 32'h1234_5678); #1;
        chk("ct2_m0_ready", m_ready, 2'b01);
        chk("ct2_m0_rdata", m_rdata[0], 32'h1234_5678);

        // Decode miss
        cyc();
        req(1'b0, 32'h4000_0000, 4'h0, 32'h0); #1;
        chk("miss_s_valid", s_valid, 4'b0000);
        chk("miss_m_ready_early", m_ready, 2'b00);
        cyc(); #1;
        chk("miss_m_ready", m_ready, 2'b01);
        chk("miss_m_error", m_error, 2'b01);
        chk("miss_m_rdata", m_rdata, 64'h0);
        chk("miss_s_valid_late", s_valid, 4'b0000);
        cyc(); #1;
        chk("miss_pulse", m_ready | m_error, 2'b00);

        // Stray s_ready on a free slave
        cyc();
        rsp(2'd1, 32'h0000_FFFF); #1;
        chk("free_rdy_m_ready", m_ready, 2'b00);
        chk("free_rdy_m_rdata", m_rdata, 64'h0);

        // Window edges: last clint word hits, uart top is exclusive
        cyc();
        req(1'b0, 32'h0200_BFFC, 4'h0, 32'h0); #1;
        chk("clint_s_valid", s_valid, 4'b0010);
        chk("clint_s_addr", s_addr[1], 32'h0000_BFFC);
        cyc();
        rsp(2'd1, 32'h1); #1;
        chk("clint_m_ready", m_ready, 2'b01);
        cyc();
        req(1'b1, 32'h0100_0004, 4'h0, 32'h0); #1;
        chk("uart_top_s_valid", s_valid, 4'b0000);
        cyc(); #1;
        chk("uart_top_err", m_error, 2'b10);

        // Concurrent masters on different slaves
        cyc();
        req(1'b0, 32'h0000_0100, 4'h0, 32'h0);
        req(1'b1, 32'h0100_0000, 4'hF, 32'hCAFE_F00D); #1;
        chk("cc_s_valid", s_valid, 4'b1100);
        chk("cc_uart_addr", s_addr[2], 32'h0);
        chk("cc_uart_wstrb", s_wstrb[2], 4'hF);
        chk("cc_uart_wdata", s_wdata[2], 32'hCAFE_F00D);
        chk("cc_bram_addr", s_addr[3], 32'h100);
        cyc();
        rsp(2'd2, 32'h0); #1;
        chk("cc_m1_ready", m_ready, 2'b10);
        cyc();
        rsp(2'd3, 32'h0000_0055); #1;
        chk("cc_m0_ready", m_ready, 2'b01);
        chk("cc_m0_rdata", m_rdata[0], 32'h55);
        cyc();
        req(1'b0, 32'h0000_0008, 4'h0, 32'h0);
        req(1'b1, 32'h0200_0004, 4'h0, 32'h0); #1;
        chk("cc2_s_valid", s_valid, 4'b1010);
        chk("cc2_clint_addr", s_addr[1], 32'h4);
        cyc();
        rsp(2'd3, 32'h0000_AAAA);
        rsp(2'd1, 32'h0000_BBBB); #1;
        chk("cc2_m_ready", m_ready, 2'b11);
        chk("cc2_m0_rdata", m_rdata[0], 32'hAAAA);
        chk("cc2_m1_rdata", m_rdata[1], 32'hBBBB);

        // Reset with M1 in flight on uart; late s_ready must be dropped
        cyc();
        req(1'b1, 32'h0100_0000, 4'h0, 32'h0); #1;
        chk("rr_s_valid", s_valid, 4'b0100);
        cyc();
        reset = 1'b1;
        rsp(2'd2, 32'h0000_0077); #1;
        chk("rr_in_reset_m_ready", m_ready, 2'b00);
        cyc();
        reset = 1'b0;
        rsp(2'd2, 32'h0000_0077); #1;
        chk("rr_after_reset_m_ready", m_ready, 2'b00);
        cyc();
        rsp(2'd2, 32'h0000_0077); #1;
        chk("rr_late_m_ready", m_ready, 2'b00);
        chk("rr_late_m_rdata", m_rdata, 64'h0);
        cyc();
        req(1'b1, 32'h0100_0000, 4'h0, 32'h0); #1;
        chk("rr_fresh_s_valid", s_valid, 4'b0100);
        chk("rr_fresh_s_addr", s_addr[2], 32'h0);
        cyc();
        rsp(2'd2, 32'h0000_0099); #1;
        chk("rr_fresh_m_ready", m_ready, 2'b10);
        chk("rr_fresh_m_rdata", m_rdata[1], 32'h99);

        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
